// File: rtl/shiftreg_pkg.sv
// Shared types for the shift-register sequencer: register modes, command
// opcodes and sequencer states, plus small opcode decode helpers.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } sr_mode_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ASR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Opcodes 6 and 7 are not shifts; they complete as zero-amount no-ops.
  function automatic logic op_is_shift(input logic [2:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

  function automatic sr_mode_e op_mode(input logic [2:0] op);
    sr_mode_e m;
    case (op)
      OP_LOAD:         m = LOAD;
      OP_SHL, OP_ROL:  m = SHL;
      OP_SHR, OP_ASR,
      OP_ROR:          m = SHR;
      default:         m = HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/shiftreg_sequencer.sv
// Command sequencer for a mode-controlled shift register: accepts one command
// at a time and drives mode/serial bits cycle by cycle until it completes.
module shiftreg_sequencer
  import shiftreg_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int CNTW     = $clog2(DATASIZE) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [2:0]          cmd_op_i,
  input  logic [CNTW-1:0]     cmd_amount_i,
  input  logic [DATASIZE-1:0] cmd_data_i,
  input  logic                cmd_fill_i,
  input  logic [DATASIZE-1:0] reg_value_i,
  output logic [1:0]          sr_mode_o,
  output logic [DATASIZE-1:0] sr_load_value_o,
  output logic                sr_ser_in_msb_o,
  output logic                sr_ser_in_lsb_o,
  output logic                busy_o,
  output logic                done_o,
  output state_e              dbg_state_o
);

  // Handshake: a command transfers on a rising edge where cmd_valid_i and
  // cmd_ready_o are both high; the source must hold the command stable
  // until then. cmd_ready_o depends on registered state only.

  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(DATASIZE);
  localparam logic [CNTW-1:0] ONE_CNT = CNTW'(1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNTW-1:0]       r_cnt;
  logic [2:0]            r_op;
  logic [DATASIZE-1:0]   r_data;
  logic                  r_fill;

  logic                  w_accept;
  logic [CNTW-1:0]       w_amt_clamped;
  logic [CNTW-1:0]       w_cnt_init;
  sr_mode_e              w_mode;

  assign w_accept      = cmd_valid_i && (r_state == IDLE);
  assign w_amt_clamped = (cmd_amount_i > MAX_CNT) ? MAX_CNT : cmd_amount_i;

  // LOAD occupies exactly one EXEC cycle; unknown opcodes get a zero count.
  always_comb begin
    w_cnt_init = '0;
    if (cmd_op_i == OP_LOAD) begin
      w_cnt_init = ONE_CNT;
    end else if (op_is_shift(cmd_op_i)) begin
      w_cnt_init = w_amt_clamped;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= w_cnt_init;
        r_op   <= cmd_op_i;
        r_data <= cmd_data_i;
        r_fill <= cmd_fill_i;
      end else if (r_state == EXEC) begin
        r_cnt <= r_cnt - ONE_CNT;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_cnt_init != '0) ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (r_cnt <= ONE_CNT) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Serial bits are combinational from reg_value_i so rotates and ASR see
  // the register contents of the current cycle.
  always_comb begin
    w_mode          = HOLD;
    sr_load_value_o = '0;
    sr_ser_in_msb_o = 1'b0;
    sr_ser_in_lsb_o = 1'b0;
    if (r_state == EXEC) begin
      w_mode = op_mode(r_op);
      case (r_op)
        OP_LOAD: sr_load_value_o = r_data;
        OP_SHL:  sr_ser_in_lsb_o = r_fill;
        OP_SHR:  sr_ser_in_msb_o = r_fill;
        OP_ASR:  sr_ser_in_msb_o = reg_value_i[DATASIZE-1];
        OP_ROL:  sr_ser_in_lsb_o = reg_value_i[DATASIZE-1];
        OP_ROR:  sr_ser_in_msb_o = reg_value_i[0];
        default: ;
      endcase
    end
  end

  assign sr_mode_o   = w_mode;
  assign cmd_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Bench for shiftreg_sequencer with an 8-bit shift register closing the
// feedback loop; table vectors, hand-written corner sequences, random commands.
module tb_shiftreg_sequencer;
  import shiftreg_pkg::*;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [CW-1:0] cmd_amount = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_fill = 1'b0;
  logic [W-1:0]  sr_q;
  logic [1:0]    sr_mode;
  logic [W-1:0]  sr_load;
  logic          ser_msb;
  logic          ser_lsb;
  logic          busy;
  logic          done;
  state_e        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  shiftreg_sequencer #(.DATASIZE(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_amount_i(cmd_amount),
    .cmd_data_i(cmd_data), .cmd_fill_i(cmd_fill),
    .reg_value_i(sr_q),
    .sr_mode_o(sr_mode), .sr_load_value_o(sr_load),
    .sr_ser_in_msb_o(ser_msb), .sr_ser_in_lsb_o(ser_lsb),
    .busy_o(busy), .done_o(done), .dbg_state_o(dbg_state)
  );

  // The shift register being sequenced, sharing the sequencer's reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else begin
      case (sr_mode)
        2'b01: sr_q <= {sr_q[W-2:0], ser_lsb};
        2'b10: sr_q <= {ser_msb, sr_q[W-1:1]};
        2'b11: sr_q <= sr_load;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected final register value from the arithmetic meaning of each op.
  function automatic logic [W-1:0] model(input logic [2:0] op, input int amt,
      input logic [W-1:0] data, input logic fill, input logic [W-1:0] v);
    int n;
    int x;
    int sv;
    int mask;
    n = (amt > W) ? W : amt;
    mask = (1 << n) - 1;
    x = v;
    case (op)
      3'd0: x = data;
      3'd1: x = (v << n) | (fill ? mask : 0);
      3'd2: x = (v >> n) | (fill ? (mask << (W - n)) : 0);
      3'd3: begin
        sv = v[W-1] ? int'(v) - (1 << W) : int'(v);
        x = sv >>> n;
      end
      3'd4: x = (v << n) | (v >> (W - n));
      3'd5: x = (v >> n) | (v << (W - n));
      default: x = v;
    endcase
    return x[W-1:0];
  endfunction

  function automatic int exp_cycles(input logic [2:0] op, input int amt);
    if (op == 3'd0) return 1;
    if (op > 3'd5) return 0;
    return (amt > W) ? W : amt;
  endfunction

  function automatic logic [1:0] exp_dir(input logic [2:0] op);
    case (op)
      3'd0: return 2'b11;
      3'd1, 3'd4: return 2'b01;
      3'd2, 3'd3, 3'd5: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Issues one command and records latency, busy/mode cycle counts and
  // whether every active cycle drove the right mode and load value.
  task automatic run_cmd(input logic [2:0] op, input int amt, input logic [W-1:0] data,
      input logic fill, output int lat, output int busy_n, output int mode_n,
      output logic dir_ok, output logic ld_ok);
    int k;
    lat = 0; busy_n = 0; mode_n = 0; dir_ok = 1'b1; ld_ok = 1'b1;
    @(negedge clk);
    cmd_op = op; cmd_amount = CW'(amt); cmd_data = data; cmd_fill = fill; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", 32'(k >= 50), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_n++;
      if (sr_mode != 2'b00) begin
        mode_n++;
        if (sr_mode != exp_dir(op)) dir_ok = 1'b0;
      end
      if ((sr_mode == 2'b11) ? (sr_load != data) : (sr_load != '0)) ld_ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_cmd(input string tag, input int lat, input int busy_n, input int mode_n,
      input logic dir_ok, input logic ld_ok, input int n);
    check({tag, "_latency"}, 32'(lat), 32'(1 + n));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(1 + n));
    check({tag, "_mode_cycles"}, 32'(mode_n), 32'(n));
    check({tag, "_mode_dir"}, 32'(dir_ok), 1);
    check({tag, "_load_value"}, 32'(ld_ok), 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_ready_after"}, 32'(cmd_ready), 1);
  endtask

  typedef struct {
    logic [2:0]   op;
    int           amt;
    logic [W-1:0] data;
    logic         fill;
    logic [W-1:0] exp_val;
    int           exp_lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat, busy_n, mode_n, k;
    logic dir_ok, ld_ok;
    logic [W-1:0] cur, exp_v;

    vecs[0]  = '{3'd0, 0,  8'hA5, 1'b0, 8'hA5, 2};
    vecs[1]  = '{3'd4, 3,  8'h00, 1'b0, 8'h2D, 4};
    vecs[2]  = '{3'd5, 3,  8'h00, 1'b0, 8'hA5, 4};
    vecs[3]  = '{3'd0, 0,  8'h81, 1'b0, 8'h81, 2};
    vecs[4]  = '{3'd3, 2,  8'h00, 1'b0, 8'hE0, 3};
    vecs[5]  = '{3'd0, 0,  8'h81, 1'b0, 8'h81, 2};
    vecs[6]  = '{3'd2, 2,  8'h00, 1'b0, 8'h20, 3};
    vecs[7]  = '{3'd1, 0,  8'hFF, 1'b1, 8'h20, 1};
    vecs[8]  = '{3'd4, 15, 8'h00, 1'b0, 8'h20, 9};
    vecs[9]  = '{3'd6, 5,  8'h77, 1'b1, 8'h20, 1};
    vecs[10] = '{3'd1, 3,  8'h00, 1'b1, 8'h07, 4};
    vecs[11] = '{3'd2, 8,  8'h00, 1'b1, 8'hFF, 9};
    vecs[12] = '{3'd3, 9,  8'h00, 1'b0, 8'hFF, 9};

    #1;
    check("reset_ready", 32'(cmd_ready), 1);
    check("reset_mode", 32'(sr_mode), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_load", 32'(sr_load), 0);
    check("reset_ser", 32'({ser_msb, ser_lsb}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].fill, lat, busy_n, mode_n, dir_ok, ld_ok);
      check($sformatf("vec%0d_value", i), 32'(sr_q), 32'(vecs[i].exp_val));
      check_cmd($sformatf("vec%0d", i), lat, busy_n, mode_n, dir_ok, ld_ok, vecs[i].exp_lat - 1);
    end

    // Command held valid through busy must not be taken again until IDLE.
    run_cmd(3'd0, 0, 8'h0F, 1'b0, lat, busy_n, mode_n, dir_ok, ld_ok);
    @(negedge clk);
    cmd_op = 3'd1; cmd_amount = 4'd2; cmd_fill = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    check("held_c1_busy", 32'(busy), 1);
    check("held_c1_mode", 32'(sr_mode), 32'b01);
    @(negedge clk);
    @(negedge clk);
    check("held_c3_done", 32'(done), 1);
    check("held_c3_ready", 32'(cmd_ready), 0);
    check("held_c3_value", 32'(sr_q), 32'h3C);
    @(negedge clk);
    check("held_c4_ready", 32'(cmd_ready), 1);
    check("held_c4_busy", 32'(busy), 0);
    @(negedge clk);
    check("held_c5_reaccept", 32'(busy), 1);
    check("held_c5_mode", 32'(sr_mode), 32'b01);
    cmd_valid = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("held_second_done", 32'(done), 1);
    check("held_second_value", 32'(sr_q), 32'hF0);

    // Reset lands after two of five shifts.
    run_cmd(3'd0, 0, 8'h0F, 1'b0, lat, busy_n, mode_n, dir_ok, ld_ok);
    @(negedge clk);
    cmd_op = 3'd1; cmd_amount = 4'd5; cmd_fill = 1'b1; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_two_shifts", 32'(sr_q), 32'h3F);
    check("mid_still_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_mode", 32'(sr_mode), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(cmd_ready), 1);
    check("mid_rst_ser", 32'({ser_msb, ser_lsb}), 0);
    check("mid_rst_reg", 32'(sr_q), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_no_done", 32'(done), 0);
    end
    rst = 1'b0;
    #1;
    check("mid_release_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    check("mid_held_accepted", 32'(busy), 1);
    cmd_valid = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_retry_done", 32'(done), 1);
    check("mid_retry_value", 32'(sr_q), 32'h1F);
    check("mid_retry_cycles", 32'(k), 5);

    // Random commands against the arithmetic model.
    cur = sr_q;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      int amt;
      logic [W-1:0] data;
      logic fill;
      op = 3'($urandom_range(0, 7));
      amt = $urandom_range(0, 15);
      data = W'($urandom);
      fill = 1'($urandom_range(0, 1));
      exp_q.push_back(model(op, amt, data, fill, cur));
      run_cmd(op, amt, data, fill, lat, busy_n, mode_n, dir_ok, ld_ok);
      exp_v = exp_q.pop_front();
      check($sformatf("rnd%0d_value op%0d amt%0d", i, op, amt), 32'(sr_q), 32'(exp_v));
      check_cmd($sformatf("rnd%0d", i), lat, busy_n, mode_n, dir_ok, ld_ok, exp_cycles(op, amt));
      cur = exp_v;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
